// File: rtl/io_pkg.sv
// io_pkg: opcodes, register index, FSM states and wait-counter width for io_sequencer.
package io_pkg;
  localparam logic [5:0] OP_OUT = 6'b111101;
  localparam logic [5:0] OP_IN = 6'b111110;
  localparam int IO_REG_IDX = 31;
  localparam int WAIT_W = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_OUT_RD,
    S_OUT_XFER,
    S_IN_WAIT,
    S_IN_WB,
    S_DONE
  } io_state_t;
endpackage

// File: rtl/io_sequencer.sv
// io_sequencer: stalls the core and runs the R[31] <-> device handshake for IN/OUT, with timeout abort.
module io_sequencer
  import io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [5:0]  op_code,
  output logic        stall,
  output logic        rf_r31_rd_en,
  input  logic [31:0] rf_rd_data,
  output logic        rf_we,
  output logic [31:0] rf_wr_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready,
  output logic [31:0] ext_out_data,
  output logic        ext_in_ready,
  input  logic        ext_in_valid,
  input  logic [31:0] ext_in_data,
  output logic        io_err
);
  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = TIMEOUT_CYCLES != 0;
  io_state_t state, nxt;
  logic [WAIT_W-1:0] cnt;
  logic err_q, wait_st, hs, tmo, is_io;
  assign is_io = op_valid && (op_code == OP_OUT || op_code == OP_IN);
  assign wait_st = state == S_OUT_XFER || state == S_IN_WAIT;
  assign hs = (state == S_OUT_XFER && ext_out_ready) || (state == S_IN_WAIT && ext_in_valid);
  // A handshake in the same cycle as the limit takes priority over the abort.
  assign tmo = TMO_EN && wait_st && !hs && cnt == TMO;
  assign stall = wait_st || state == S_OUT_RD || state == S_IN_WB || (state == S_IDLE && is_io);
  assign rf_r31_rd_en = state == S_OUT_RD;
  assign ext_out_valid = state == S_OUT_XFER;
  assign ext_in_ready = state == S_IN_WAIT;
  assign rf_we = state == S_IN_WB;
  assign io_err = err_q;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = !op_valid ? S_IDLE : op_code == OP_OUT ? S_OUT_RD :
                        op_code == OP_IN ? S_IN_WAIT : S_IDLE;
      S_OUT_RD:   nxt = S_OUT_XFER;
      S_OUT_XFER: nxt = hs ? S_DONE : tmo ? S_DONE : S_OUT_XFER;
      S_IN_WAIT:  nxt = hs ? S_IN_WB : tmo ? S_DONE : S_IN_WAIT;
      S_IN_WB:    nxt = S_DONE;
      default:    nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      ext_out_data <= '0;
      rf_wr_data <= '0;
    end else begin
      state <= nxt;
      err_q <= tmo;
      cnt <= (wait_st && nxt == state) ? cnt + 1'b1 : '0;
      if (state == S_OUT_RD) ext_out_data <= rf_rd_data;
      if (state == S_IN_WAIT && ext_in_valid) rf_wr_data <= ext_in_data;
    end
  end
endmodule

// File: tb/tb_io_sequencer.sv
// tb_io_sequencer: directed vector table plus hand-written multi-cycle sequences for io_sequencer.
module tb_io_sequencer;
  import io_pkg::*;
  logic clk = 0, rst = 1;
  logic op_valid = 0, ext_out_ready = 0, ext_in_valid = 0;
  logic [5:0] op_code = '0;
  logic [31:0] rf_rd_data = '0, ext_in_data = '0;
  logic stall, rd_en, we, ovld, irdy, err;
  logic [31:0] wdat, odat;
  logic stall4, rd_en4, we4, ovld4, irdy4, err4;
  logic [31:0] wdat4, odat4;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  io_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .stall(stall),
    .rf_r31_rd_en(rd_en), .rf_rd_data(rf_rd_data), .rf_we(we), .rf_wr_data(wdat),
    .ext_out_valid(ovld), .ext_out_ready(ext_out_ready), .ext_out_data(odat),
    .ext_in_ready(irdy), .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .io_err(err)
  );

  io_sequencer #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .stall(stall4),
    .rf_r31_rd_en(rd_en4), .rf_rd_data(rf_rd_data), .rf_we(we4), .rf_wr_data(wdat4),
    .ext_out_valid(ovld4), .ext_out_ready(ext_out_ready), .ext_out_data(odat4),
    .ext_in_ready(irdy4), .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .io_err(err4)
  );

  typedef struct {
    logic ov;
    logic [5:0] op;
    logic ordy, ivld;
    logic [31:0] idat;
    logic [5:0] flags;
    logic [31:0] odat, wdat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    op_valid = 0;
    ext_out_ready = 0;
    ext_in_valid = 0;
    repeat (2) @(posedge clk);
    #3 rst = 0;
  endtask

  task automatic drive(input logic ov, input logic [5:0] op, input logic ordy, input logic ivld,
                       input logic [31:0] idat);
    @(posedge clk);
    #1;
    op_valid = ov;
    op_code = op;
    ext_out_ready = ordy;
    ext_in_valid = ivld;
    ext_in_data = idat;
    #1;
  endtask

  vec_t v[12];
  int sc, wc, ec, ek, xc;

  initial begin
    rf_rd_data = 32'hDEADBEEF;
    // flags = {stall, rd_en, out_valid, in_ready, we, err}
    v[0]  = '{1, OP_OUT, 1, 0, 0, 6'b100000, 32'h0, 32'h0};
    v[1]  = '{1, OP_OUT, 1, 0, 0, 6'b110000, 32'h0, 32'h0};
    v[2]  = '{1, OP_OUT, 1, 0, 0, 6'b101000, 32'hDEADBEEF, 32'h0};
    v[3]  = '{1, OP_OUT, 1, 0, 0, 6'b000000, 32'hDEADBEEF, 32'h0};
    v[4]  = '{0, OP_OUT, 0, 0, 0, 6'b000000, 32'hDEADBEEF, 32'h0};
    v[5]  = '{1, OP_IN, 0, 1, 32'hCAFEF00D, 6'b100000, 32'hDEADBEEF, 32'h0};
    v[6]  = '{1, OP_IN, 0, 1, 32'hCAFEF00D, 6'b100100, 32'hDEADBEEF, 32'h0};
    v[7]  = '{1, OP_IN, 0, 1, 32'hCAFEF00D, 6'b100010, 32'hDEADBEEF, 32'hCAFEF00D};
    v[8]  = '{1, OP_IN, 0, 1, 32'hCAFEF00D, 6'b000000, 32'hDEADBEEF, 32'hCAFEF00D};
    v[9]  = '{1, 6'b000001, 1, 1, 32'h5, 6'b000000, 32'hDEADBEEF, 32'hCAFEF00D};
    v[10] = '{1, 6'b000001, 1, 1, 32'h6, 6'b000000, 32'hDEADBEEF, 32'hCAFEF00D};
    v[11] = '{0, 6'b000000, 0, 0, 32'h0, 6'b000000, 32'hDEADBEEF, 32'hCAFEF00D};

    #1;
    chk("reset_flags", {26'd0, stall, rd_en, ovld, irdy, we, err}, 32'h0);
    chk("reset_odat", odat, 32'h0);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(v[i].ov, v[i].op, v[i].ordy, v[i].ivld, v[i].idat);
      chk($sformatf("vec%0d_flags", i), {26'd0, stall, rd_en, ovld, irdy, we, err}, {26'd0, v[i].flags});
      chk($sformatf("vec%0d_odat", i), odat, v[i].odat);
      chk($sformatf("vec%0d_wdat", i), wdat, v[i].wdat);
    end

    // IN with device valid five cycles late
    do_reset();
    sc = 0;
    wc = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1, OP_IN, 0, k >= 6, 32'h0000_1234);
      if (we) begin
        wc++;
        chk("late_in_wdat", wdat, 32'h0000_1234);
      end
      if (!stall) break;
      sc++;
    end
    chk("late_in_stall_cycles", sc, 8);
    chk("late_in_we_count", wc, 1);

    // silent device, timeout 4
    do_reset();
    wc = 0;
    ec = 0;
    ek = -1;
    for (int k = 0; k < 12; k++) begin
      drive(k <= 6, OP_IN, 0, 0, 32'hFFFF_FFFF);
      if (we4) wc++;
      if (err4) begin
        ec++;
        ek = k;
      end
    end
    chk("tmo_err_count", ec, 1);
    chk("tmo_err_cycle", ek, 6);
    chk("tmo_we_count", wc, 0);
    chk("tmo_idle", {30'd0, stall4, irdy4}, 32'h0);
    chk("tmo_wdat", wdat4, 32'h0);

    // handshake on the same cycle the counter reaches the limit
    do_reset();
    wc = 0;
    ec = 0;
    for (int k = 0; k < 10; k++) begin
      drive(k <= 7, OP_IN, 0, k == 5, 32'h0000_ABCD);
      if (we4) wc++;
      if (err4) ec++;
    end
    chk("race_we_count", wc, 1);
    chk("race_err_count", ec, 0);
    chk("race_wdat", wdat4, 32'h0000_ABCD);

    // two OUTs with the op held through DONE
    do_reset();
    xc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, OP_OUT, 1, 0, 32'h0);
      if (ovld && ext_out_ready) xc++;
    end
    drive(0, OP_OUT, 1, 0, 32'h0);
    chk("b2b_xfers", xc, 2);
    chk("b2b_stall_after", {31'd0, stall}, 32'h0);

    // async reset in OUT_XFER
    do_reset();
    rf_rd_data = 32'h55AA_55AA;
    for (int k = 0; k < 3; k++) drive(1, OP_OUT, 0, 0, 32'h0);
    chk("mid_ovld", {31'd0, ovld}, 32'h1);
    chk("mid_odat", odat, 32'h55AA_55AA);
    #2;
    rst = 1;
    op_valid = 0;
    #1;
    chk("async_rst_flags", {26'd0, stall, rd_en, ovld, irdy, we, err}, 32'h0);
    chk("async_rst_odat", odat, 32'h0);
    chk("async_rst_wdat", wdat, 32'h0);
    @(posedge clk);
    #3 rst = 0;
    wc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(k <= 3, OP_IN, 0, 1, 32'h0000_0077);
      if (we) begin
        wc++;
        chk("post_rst_wdat", wdat, 32'h0000_0077);
      end
    end
    chk("post_rst_we_count", wc, 1);
    chk("post_rst_idle", {31'd0, stall}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
